// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for a single register-file port.
// Each master gets a one-deep request slot; requests are granted round-robin
// and serialised onto the register bus. Read data is returned to the owning
// master together with a one-cycle valid pulse.
module reg_bus_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int RD_LATENCY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_wr,
    input  logic          m0_rd,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    output logic          m0_busy,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_wr,
    input  logic          m1_rd,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic          m1_busy,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_wr,
    output logic          reg_rd,
    input  logic [DW-1:0] reg_rdata,
    output logic [1:0]    ovf,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bus-side state
    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          cur_wr_q, cur_wr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;

    // Per-master request slots, read data and overflow flags
    logic [1:0]    pend_q, pend_d;
    logic [AW-1:0] slot_addr_q [2];
    logic [AW-1:0] slot_addr_d [2];
    logic [DW-1:0] slot_wdata_q [2];
    logic [DW-1:0] slot_wdata_d [2];
    logic [1:0]    slot_wr_q, slot_wr_d;
    logic [DW-1:0] rdata_q [2];
    logic [DW-1:0] rdata_d [2];
    logic [1:0]    ovf_q, ovf_d;

    // Per-master views of the input ports and derived request terms
    logic [AW-1:0] in_addr [2];
    logic [DW-1:0] in_wdata [2];
    logic [1:0]    in_wr, in_rd;
    logic [1:0]    strobe, busy, accept, ovf_set, req, req_wr;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wdata [2];

    logic in_service;
    logic grant_en;
    logic win;
    logic rd_capture;

    assign in_addr[0]  = m0_addr;
    assign in_addr[1]  = m1_addr;
    assign in_wdata[0] = m0_wdata;
    assign in_wdata[1] = m1_wdata;
    assign in_wr       = {m1_wr, m0_wr};
    assign in_rd       = {m1_rd, m0_rd};

    // Owner stays busy through ISSUE/WAIT; RESP already frees it so a new
    // strobe can land in the rvalid cycle.
    assign in_service = (state_q == ISSUE) || (state_q == WAIT);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            localparam logic ID = 1'(gi);
            assign strobe[gi]    = in_wr[gi] | in_rd[gi];
            assign busy[gi]      = pend_q[gi] | (in_service && (owner_q == ID));
            assign accept[gi]    = strobe[gi] & ~busy[gi];
            // Dropped strobe, or a read lost to a simultaneous write.
            assign ovf_set[gi]   = (strobe[gi] & busy[gi]) | (in_wr[gi] & in_rd[gi]);
            // An empty slot is bypassed so an idle arbiter can grant at once.
            assign req[gi]       = pend_q[gi] | accept[gi];
            assign req_addr[gi]  = pend_q[gi] ? slot_addr_q[gi]  : in_addr[gi];
            assign req_wdata[gi] = pend_q[gi] ? slot_wdata_q[gi] : in_wdata[gi];
            assign req_wr[gi]    = pend_q[gi] ? slot_wr_q[gi]    : in_wr[gi];
        end
    endgenerate

    assign grant_en   = (state_q == IDLE) && (req != 2'b00);
    assign win        = (req == 2'b11) ? ~last_q : req[1];
    assign rd_capture = ((state_q == ISSUE) && !cur_wr_q && (RD_LATENCY == 0)) ||
                        ((state_q == WAIT) && (cnt_q == 2'd1));

    // Next-state and bus-side register loads for the access sequencer
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cur_wr_d    = cur_wr_q;
        cnt_d       = cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    owner_d     = win;
                    last_d      = win;
                    cur_wr_d    = req_wr[win];
                    reg_addr_d  = req_addr[win];
                    reg_wdata_d = req_wdata[win];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_wr_q) begin
                    state_d = IDLE;
                end else if (RD_LATENCY == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LATENCY);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slot capture/release, read-data capture and sticky overflow update
    always_comb begin
        pend_d    = pend_q;
        slot_wr_d = slot_wr_q;
        for (int i = 0; i < 2; i++) begin
            slot_addr_d[i]  = slot_addr_q[i];
            slot_wdata_d[i] = slot_wdata_q[i];
            rdata_d[i]      = rdata_q[i];
            if (grant_en && (win == 1'(i))) begin
                pend_d[i] = 1'b0;
            end else if (accept[i]) begin
                pend_d[i]       = 1'b1;
                slot_addr_d[i]  = in_addr[i];
                slot_wdata_d[i] = in_wdata[i];
                slot_wr_d[i]    = in_wr[i];
            end
            if (rd_capture && (owner_q == 1'(i))) begin
                rdata_d[i] = reg_rdata;
            end
        end
        ovf_d = (ovf_q & ~{2{ovf_clr}}) | ovf_set;
    end

    // State register; asynchronous reset aborts any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cur_wr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            pend_q      <= 2'b00;
            slot_wr_q   <= 2'b00;
            ovf_q       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                rdata_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cur_wr_q    <= cur_wr_d;
            cnt_q       <= cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            pend_q      <= pend_d;
            slot_wr_q   <= slot_wr_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= slot_addr_d[i];
                slot_wdata_q[i] <= slot_wdata_d[i];
                rdata_q[i]      <= rdata_d[i];
            end
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = (state_q == ISSUE) &&  cur_wr_q;
    assign reg_rd    = (state_q == ISSUE) && !cur_wr_q;
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_rvalid = (state_q == RESP) && (owner_q == 1'b0);
    assign m1_rvalid = (state_q == RESP) && (owner_q == 1'b1);
    assign m0_busy   = busy[0];
    assign m1_busy   = busy[1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: three instances (read latency 0, 2, 3) share one
// stimulus stream; each has its own register-file stand-in and a timing
// reference model that predicts every output from request arrival times.
module tb_reg_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_wr, m0_rd, m1_wr, m1_rd;
    logic       ovf_clr;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);

        logic [7:0] m0_rdata, m1_rdata, reg_addr, reg_wdata, reg_rdata;
        logic       m0_rvalid, m0_busy, m1_rvalid, m1_busy, reg_wr, reg_rd;
        logic [1:0] ovf;

        reg_bus_arbiter #(.AW(8), .DW(8), .RD_LATENCY(L)) dut (
            .clk(clk), .rst(rst),
            .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr), .m0_rd(m0_rd),
            .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_busy(m0_busy),
            .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr), .m1_rd(m1_rd),
            .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_busy(m1_busy),
            .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
            .reg_rdata(reg_rdata), .ovf(ovf), .ovf_clr(ovf_clr)
        );

        // Register-file stand-in: data is correct only exactly L cycles after
        // the reg_rd cycle, inverted otherwise, so a mistimed capture shows up.
        logic [7:0] mem [256];
        logic [2:0] rd_dly;
        logic [3:0] rd_vec;
        always @(posedge clk or posedge rst) begin
            if (rst) rd_dly <= '0;
            else     rd_dly <= {rd_dly[1:0], reg_rd};
        end
        always @(posedge clk) begin
            if (reg_wr) mem[reg_addr] = reg_wdata;
        end
        assign rd_vec    = {rd_dly, reg_rd};
        assign reg_rdata = rd_vec[L] ? mem[reg_addr] : ~mem[reg_addr];

        // Reference model state: pending requests, the access in service with
        // its issue/rvalid cycle numbers, and the cycle the bus is free again.
        logic [7:0] mmem [256];
        bit         pend [2];
        logic [7:0] p_addr [2];
        logic [7:0] p_wdata [2];
        bit         p_wr [2];
        bit         s_on, s_wr;
        int         s_own, s_issue, s_rvalid, free_at, last;
        logic [7:0] s_addr, s_wdata, s_data;
        logic [7:0] e_rdata [2];
        logic [1:0] e_ovf;

        initial begin
            for (int a = 0; a < 256; a++) begin
                mem[a]  = 8'(a) ^ 8'hA7;
                mmem[a] = 8'(a) ^ 8'hA7;
            end
        end

        always @(negedge clk) begin : model
            bit         e_busy [2];
            bit         acc [2];
            bit         wr_in [2];
            bit         rd_in [2];
            logic [7:0] a_in [2];
            logic [7:0] d_in [2];
            bit         exp_wr, exp_rd, exp_rv0, exp_rv1, granted, c0, c1;
            int         w;
            string      pfx;
            pfx = $sformatf("L%0d", L);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    pend[i]    = 1'b0;
                    e_rdata[i] = 8'h00;
                end
                s_on = 1'b0; s_wr = 1'b0; s_own = 0; s_issue = 0; s_rvalid = 0;
                free_at = 0; last = 1; e_ovf = 2'b00;
                check({pfx, " rst_busy"},   32'({m1_busy, m0_busy}), 32'd0);
                check({pfx, " rst_rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'd0);
                check({pfx, " rst_rdata"},  32'({m1_rdata, m0_rdata}), 32'd0);
                check({pfx, " rst_bus"},    32'({reg_wr, reg_rd, reg_addr, reg_wdata}), 32'd0);
                check({pfx, " rst_ovf"},    32'(ovf), 32'd0);
            end else begin
                wr_in[0] = m0_wr; rd_in[0] = m0_rd; a_in[0] = m0_addr; d_in[0] = m0_wdata;
                wr_in[1] = m1_wr; rd_in[1] = m1_rd; a_in[1] = m1_addr; d_in[1] = m1_wdata;
                for (int i = 0; i < 2; i++) begin
                    e_busy[i] = pend[i] ||
                                (s_on && s_own == i && (s_wr ? cyc <= s_issue : cyc < s_rvalid));
                end
                exp_wr  = s_on &&  s_wr && cyc == s_issue;
                exp_rd  = s_on && !s_wr && cyc == s_issue;
                exp_rv0 = s_on && !s_wr && cyc == s_rvalid && s_own == 0;
                exp_rv1 = s_on && !s_wr && cyc == s_rvalid && s_own == 1;
                if (exp_rv0) e_rdata[0] = s_data;
                if (exp_rv1) e_rdata[1] = s_data;

                check({pfx, " m0_busy"},   32'(m0_busy),   32'(e_busy[0]));
                check({pfx, " m1_busy"},   32'(m1_busy),   32'(e_busy[1]));
                check({pfx, " m0_rvalid"}, 32'(m0_rvalid), 32'(exp_rv0));
                check({pfx, " m1_rvalid"}, 32'(m1_rvalid), 32'(exp_rv1));
                check({pfx, " m0_rdata"},  32'(m0_rdata),  32'(e_rdata[0]));
                check({pfx, " m1_rdata"},  32'(m1_rdata),  32'(e_rdata[1]));
                check({pfx, " ovf"},       32'(ovf),       32'(e_ovf));
                check({pfx, " reg_wr"},    32'(reg_wr),    32'(exp_wr));
                check({pfx, " reg_rd"},    32'(reg_rd),    32'(exp_rd));
                if (exp_wr || exp_rd) begin
                    check({pfx, " reg_addr"}, 32'(reg_addr), 32'(s_addr));
                    if (L == 0)
                        $display("txn cyc=%0d m%0d %s addr=%02h wdata=%02h", cyc, s_own,
                                 exp_wr ? "wr" : "rd", s_addr, s_wdata);
                end
                if (exp_wr) begin
                    check({pfx, " reg_wdata"}, 32'(reg_wdata), 32'(s_wdata));
                    mmem[s_addr] = s_wdata;
                end

                // Acceptance and overflow
                for (int i = 0; i < 2; i++) begin
                    acc[i] = (wr_in[i] || rd_in[i]) && !e_busy[i];
                    if (((wr_in[i] || rd_in[i]) && e_busy[i]) || (wr_in[i] && rd_in[i]))
                        e_ovf[i] = 1'b1;
                    else if (ovf_clr)
                        e_ovf[i] = 1'b0;
                end

                // Round-robin grant whenever the bus is idle in this cycle
                granted = 1'b0;
                w = 0;
                if (cyc >= free_at) begin
                    c0 = pend[0] || acc[0];
                    c1 = pend[1] || acc[1];
                    if (c0 || c1) begin
                        w = (c0 && c1) ? 1 - last : (c1 ? 1 : 0);
                        granted = 1'b1;
                        if (pend[w]) begin
                            s_addr = p_addr[w]; s_wdata = p_wdata[w]; s_wr = p_wr[w];
                            pend[w] = 1'b0;
                        end else begin
                            s_addr = a_in[w]; s_wdata = d_in[w]; s_wr = wr_in[w];
                        end
                        s_on    = 1'b1;
                        s_own   = w;
                        s_issue = cyc + 1;
                        s_data  = mmem[s_addr];
                        last    = w;
                        if (s_wr) begin
                            free_at = cyc + 2;
                        end else begin
                            s_rvalid = cyc + 2 + L;
                            free_at  = cyc + 3 + L;
                        end
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (acc[i] && !(granted && w == i)) begin
                        pend[i]    = 1'b1;
                        p_addr[i]  = a_in[i];
                        p_wdata[i] = d_in[i];
                        p_wr[i]    = wr_in[i];
                    end
                end
            end
        end
    end

    // One cycle of master strobes (and optional ovf_clr), then back to quiet
    task automatic drive(input logic w0, input logic r0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic w1, input logic r1, input logic [7:0] a1, input logic [7:0] d1,
                         input logic clr);
        m0_wr = w0; m0_rd = r0; m0_addr = a0; m0_wdata = d0;
        m1_wr = w1; m1_rd = r1; m1_addr = a1; m1_wdata = d1;
        ovf_clr = clr;
        @(posedge clk); #1;
        m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int r;
        rst = 1'b1;
        m0_wr = 1'b0; m0_rd = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_wr = 1'b0; m1_rd = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Single write, then m1 read of address 0
        drive(1'b1, 1'b0, 8'h05, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        idle(8);

        // Simultaneous strobes, repeated, then after a lone m0 write
        repeat (2) begin
            drive(1'b1, 1'b0, 8'h20, 8'hF0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0);
            idle(8);
        end
        drive(1'b1, 1'b0, 8'h21, 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 8'h20, 8'hF0, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0);
        idle(8);

        // Both masters writing together: alternating grants
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + k), 8'(k), 1'b1, 1'b0, 8'(8'h50 + k), 8'(8'h80 + k), 1'b0);
            idle(2);
        end
        idle(4);

        // Overflow, clear, and clear racing a new drop
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h06, 8'h00, 1'b0);
        idle(6);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h06, 8'h00, 1'b1);
        idle(6);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(2);

        // wr+rd collision on m0, then read the location back
        drive(1'b1, 1'b1, 8'h30, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(4);
        drive(1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(8);

        // Reset while a read sits in WAIT, then a clean read
        drive(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(8);

        // Randomised traffic with occasional clears and resets
        repeat (800) begin
            r = $urandom_range(0, 99);
            m0_wr = (r < 12) || (r >= 24 && r < 26);
            m0_rd = (r >= 12 && r < 26);
            r = $urandom_range(0, 99);
            m1_wr = (r < 12) || (r >= 24 && r < 26);
            m1_rd = (r >= 12 && r < 26);
            m0_addr  = 8'($urandom_range(0, 15));
            m1_addr  = 8'($urandom_range(0, 15));
            m0_wdata = 8'($urandom);
            m1_wdata = 8'($urandom);
            ovf_clr  = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
